query_frame_loader: RTL and testbench
=====================================

# query_frame_loader

Host-to-engine command framer and result buffer for the search datapath. It receives 32-bit words from the host debug bus and frames them into a query vector, k, and a start vertex id. It issues each frame to the search engine over a valid/ready handshake, times the search in cycles, and buffers the engine's result ids in a first-word-fall-through queue for host readout. It generalises the fixed-DIM loader logic in the top level with explicit strobes, a back-pressured issue port, overflow reporting and resync on the sync word.

## Interface
Clock is `clk_in`; reset is `rst_in`, synchronous and active-high. One clock domain.
- DIM, 4, query vector length (≥1)
- WIDTH, 32, host word and query element width
- RES_DEPTH, 8, result queue entries (power of two, ≥2)
- SYNC_WORD, 32'hFFFF_FFFF, frame start marker
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- host_word_in  in  WIDTH  host data word
- host_word_valid_in  in  1  one-cycle strobe qualifying host_word_in
- query_out  out  DIM×WIDTH  framed query vector, element 0 = first word after sync
- k_out  out  16  low 16 bits of frame word DIM
- vertex_id_out  out  32  frame word DIM+1
- query_valid_out  out  1  frame ready for engine
- query_ready_in  in  1  engine accepts frame
- result_in  in  32  engine result id
- result_valid_in  in  1  result_in qualifier
- result_last_in  in  1  final result of this search (qualified by result_valid_in)
- result_out  out  32  head of result queue
- result_valid_out  out  1  queue non-empty
- result_ack_in  in  1  pop head
- cycles_out  out  32  search latency of last/current frame
- busy_out  out  1  state ≠ IDLE and ≠ COLLECT
- overflow_out  out  1  sticky: result dropped on full queue
- dropped_out  out  1  sticky: host word ignored while busy
- state_out  out  3  current state encoding, for LEDs

## Operation
- States: IDLE=0, COLLECT=1, ISSUE=2, RUN=3, DONE=4.
- IDLE: a strobed SYNC_WORD → COLLECT, word index ← 0; other words ignored silently.
- COLLECT: each strobed non-sync word is stored at the index, and the index increments. SYNC_WORD restarts the index at 0. When index DIM+1 is stored → ISSUE.
- ISSUE: query_valid_out=1; query_out/k_out/vertex_id_out held stable. On entry, the result queue is cleared and overflow_out and cycles_out are cleared. When query_valid_out&&query_ready_in → RUN.
- RUN: each result_valid_in is pushed. When result_valid_in&&result_last_in → DONE (that result is pushed too).
- DONE: one cycle → IDLE. Queue contents remain readable until the next ISSUE.
- Host strobes in ISSUE/RUN/DONE are discarded and set dropped_out. dropped_out clears on the next SYNC_WORD accepted in IDLE.
- Full queue push (no simultaneous pop) drops the word and sets overflow_out.
- Push and pop in the same cycle: allowed at any fill level, including full; the count is unchanged.
- Pop on empty: ignored.
- Results arriving outside RUN: ignored.
- Reset: all outputs 0, state IDLE, queue empty, index 0, stickies cleared. Reset mid-frame abandons the frame with no issue.

## Timing
- query_valid_out rises the cycle after the strobe of word DIM+1. No combinational path from query_ready_in to query_valid_out.
- Queue is first-word-fall-through: a push at cycle t makes result_valid_out=1 and result_out valid at t+1 when previously empty. A pop at t presents the next head at t+1.
- cycles_out: starts counting the cycle after the handshake and increments each RUN cycle, including the result_last_in cycle. It saturates at 2^32−1 and holds after DONE.
- state_out is registered and equals the current state.

## Configuration
- `QFL_CYCLE_COUNT_EN` defined: cycles_out counter implemented as above.
- Not defined: no counter logic; cycles_out tied to 0. All other behaviour is identical.

## Structure
- Package `qfl_pkg`: state enum typedef `qfl_state_t` (3-bit), constant FRAME_EXTRA=2 (k and vertex words), default SYNC_WORD.
- Sub-module `qfl_result_fifo`: parametrised WIDTH/DEPTH FWFT queue with clear, push, pop, full, empty and a same-cycle push/pop on full. The framer FSM and counter stay in the top module.

## Test plan
- DIM=4, RES_DEPTH=8, sequence FFFFFFFF,5,7,1,1,3,42 with query_ready_in=1 → query_out={5,7,1,1}, k_out=3, vertex_id_out=42; query_valid_out high exactly one cycle, state 2→3.
- Sequence FFFFFFFF,9,9,FFFFFFFF,5,7,1,1,3,42 → resync; outputs as in the previous case, no stale 9s.
- Hold query_ready_in=0 for 10 cycles after framing → query_valid_out and the payload stay stable; handshake on cycle 11; host strobes during the wait set dropped_out.
- Engine returns ids 10..19 (last on 19), no pops → queue holds 10..17, overflow_out=1, DONE reached, pops return 10..17 and then result_valid_out=0.
- Queue full at 8, push and pop in the same cycle → count stays 8, no overflow, order preserved.
- result_last_in 25 cycles after handshake → cycles_out=25 with QFL_CYCLE_COUNT_EN, 0 without. Assert rst_in during RUN → all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/qfl_pkg.sv
// Shared types and constants for the query frame loader: FSM state encoding,
// frame layout and default frame start marker.
package qfl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_ISSUE   = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4
    } qfl_state_t;

    // Words following the query elements: k, then start vertex id.
    localparam int FRAME_EXTRA = 2;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/qfl_result_fifo.sv
// First-word-fall-through result queue with synchronous clear. A push into a
// full queue is accepted only when a pop happens in the same cycle.
module qfl_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clr_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty_out,
    output logic             full_out
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = pop_in && !w_empty;
    // When full, the slot being written is the head that is leaving this cycle.
    assign w_push  = push_in && (!w_full || w_pop);

    always_ff @(posedge clk_in) begin
        if (w_push)
            r_mem[r_wr] <= data_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clr_in) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign data_out  = w_empty ? '0 : r_mem[r_rd];
    assign empty_out = w_empty;
    assign full_out  = w_full;

endmodule

// File: rtl/query_frame_loader.sv
// Frames host words into a query/k/vertex command, issues it to the search engine
// and buffers result ids. Optional latency counter: define QFL_CYCLE_COUNT_EN.
module query_frame_loader
    import qfl_pkg::*;
#(
    parameter int               DIM       = 4,
    parameter int               WIDTH     = 32,
    parameter int               RES_DEPTH = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEFAULT_SYNC_WORD)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [WIDTH-1:0]          host_word_in,
    input  logic                      host_word_valid_in,
    output logic [DIM-1:0][WIDTH-1:0] query_out,
    output logic [15:0]               k_out,
    output logic [31:0]               vertex_id_out,
    output logic                      query_valid_out,
    input  logic                      query_ready_in,
    input  logic [31:0]               result_in,
    input  logic                      result_valid_in,
    input  logic                      result_last_in,
    output logic [31:0]               result_out,
    output logic                      result_valid_out,
    input  logic                      result_ack_in,
    output logic [31:0]               cycles_out,
    output logic                      busy_out,
    output logic                      overflow_out,
    output logic                      dropped_out,
    output logic [2:0]                state_out
);

    localparam int LAST_IDX = DIM + FRAME_EXTRA - 1;
    localparam int IDXW     = $clog2(LAST_IDX + 2);

    qfl_state_t               r_state;
    qfl_state_t               w_next;
    logic [IDXW-1:0]          r_idx;
    logic [DIM-1:0][WIDTH-1:0] r_query;
    logic [15:0]              r_k;
    logic [31:0]              r_vid;
    logic                     r_overflow;
    logic                     r_dropped;

    logic w_sync;
    logic w_data;
    logic w_enter_issue;
    logic w_push_req;
    logic w_fifo_empty;
    logic w_fifo_full;

    assign w_sync     = host_word_valid_in && (host_word_in == SYNC_WORD);
    assign w_data     = host_word_valid_in && (host_word_in != SYNC_WORD);
    assign w_push_req = (r_state == S_RUN) && result_valid_in;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_sync) w_next = S_COLLECT;
            S_COLLECT: if (w_data && r_idx == IDXW'(LAST_IDX)) w_next = S_ISSUE;
            S_ISSUE:   if (query_ready_in) w_next = S_RUN;
            S_RUN:     if (result_valid_in && result_last_in) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    assign w_enter_issue = (r_state == S_COLLECT) && (w_next == S_ISSUE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_idx      <= '0;
            r_query    <= '0;
            r_k        <= '0;
            r_vid      <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_sync) begin
                    r_idx     <= '0;
                    r_dropped <= 1'b0;
                end
                S_COLLECT: if (w_sync) begin
                    r_idx <= '0;
                end else if (w_data) begin
                    for (int i = 0; i < DIM; i++)
                        if (r_idx == IDXW'(i)) r_query[i] <= host_word_in;
                    if (r_idx == IDXW'(DIM))      r_k   <= host_word_in[15:0];
                    if (r_idx == IDXW'(LAST_IDX)) r_vid <= 32'(host_word_in);
                    r_idx <= r_idx + 1'b1;
                end
                default: if (host_word_valid_in) r_dropped <= 1'b1;
            endcase

            if (w_enter_issue)
                r_overflow <= 1'b0;
            else if (w_push_req && w_fifo_full && !result_ack_in)
                r_overflow <= 1'b1;
        end
    end

    qfl_result_fifo #(
        .WIDTH (32),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_in    (w_enter_issue),
        .push_in   (w_push_req),
        .data_in   (result_in),
        .pop_in    (result_ack_in),
        .data_out  (result_out),
        .empty_out (w_fifo_empty),
        .full_out  (w_fifo_full)
    );

`ifdef QFL_CYCLE_COUNT_EN
    logic [31:0] r_cycles;

    // Counts every RUN cycle, including the one carrying result_last_in; saturates.
    always_ff @(posedge clk_in) begin
        if (rst_in || w_enter_issue)
            r_cycles <= '0;
        else if (r_state == S_RUN && r_cycles != '1)
            r_cycles <= r_cycles + 1'b1;
    end

    assign cycles_out = r_cycles;
`else
    assign cycles_out = '0;
`endif

    assign query_out        = r_query;
    assign k_out            = r_k;
    assign vertex_id_out    = r_vid;
    assign query_valid_out  = (r_state == S_ISSUE);
    assign result_valid_out = !w_fifo_empty;
    assign busy_out         = (r_state == S_ISSUE) || (r_state == S_RUN) || (r_state == S_DONE);
    assign overflow_out     = r_overflow;
    assign dropped_out      = r_dropped;
    assign state_out        = r_state;

endmodule

// File: tb/tb_query_frame_loader.sv
// Directed self-checking bench for query_frame_loader (DIM=4, RES_DEPTH=8).
// Expected cycles_out follows QFL_CYCLE_COUNT_EN.
module tb_query_frame_loader;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [31:0]       host_word_in;
    logic              host_word_valid_in;
    logic [3:0][31:0]  query_out;
    logic [15:0]       k_out;
    logic [31:0]       vertex_id_out;
    logic              query_valid_out;
    logic              query_ready_in;
    logic [31:0]       result_in;
    logic              result_valid_in;
    logic              result_last_in;
    logic [31:0]       result_out;
    logic              result_valid_out;
    logic              result_ack_in;
    logic [31:0]       cycles_out;
    logic              busy_out;
    logic              overflow_out;
    logic              dropped_out;
    logic [2:0]        state_out;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] QV = {32'd1, 32'd1, 32'd7, 32'd5};

    always #5 clk_in = ~clk_in;

    query_frame_loader #(
        .DIM       (4),
        .WIDTH     (32),
        .RES_DEPTH (8)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .host_word_in       (host_word_in),
        .host_word_valid_in (host_word_valid_in),
        .query_out          (query_out),
        .k_out              (k_out),
        .vertex_id_out      (vertex_id_out),
        .query_valid_out    (query_valid_out),
        .query_ready_in     (query_ready_in),
        .result_in          (result_in),
        .result_valid_in    (result_valid_in),
        .result_last_in     (result_last_in),
        .result_out         (result_out),
        .result_valid_out   (result_valid_out),
        .result_ack_in      (result_ack_in),
        .cycles_out         (cycles_out),
        .busy_out           (busy_out),
        .overflow_out       (overflow_out),
        .dropped_out        (dropped_out),
        .state_out          (state_out)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cyc(input int n);
`ifdef QFL_CYCLE_COUNT_EN
        return 32'(n);
`else
        return 32'd0 & 32'(n);
`endif
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        host_word_in       = w;
        host_word_valid_in = 1'b1;
        tick();
        host_word_valid_in = 1'b0;
    endtask

    task automatic push(input logic [31:0] r, input logic last, input logic ack);
        result_in       = r;
        result_valid_in = 1'b1;
        result_last_in  = last;
        result_ack_in   = ack;
        tick();
        result_valid_in = 1'b0;
        result_last_in  = 1'b0;
        result_ack_in   = 1'b0;
    endtask

    task automatic pop();
        result_ack_in = 1'b1;
        tick();
        result_ack_in = 1'b0;
    endtask

    task automatic send_frame();
        send(32'hFFFF_FFFF);
        send(32'd5); send(32'd7); send(32'd1); send(32'd1); send(32'd3); send(32'd42);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".state"},    128'(state_out), 128'd0);
        check({tag, ".qvalid"},   128'(query_valid_out), 128'd0);
        check({tag, ".query"},    query_out, 128'd0);
        check({tag, ".k"},        128'(k_out), 128'd0);
        check({tag, ".vid"},      128'(vertex_id_out), 128'd0);
        check({tag, ".rvalid"},   128'(result_valid_out), 128'd0);
        check({tag, ".rout"},     128'(result_out), 128'd0);
        check({tag, ".cycles"},   128'(cycles_out), 128'd0);
        check({tag, ".busy"},     128'(busy_out), 128'd0);
        check({tag, ".overflow"}, 128'(overflow_out), 128'd0);
        check({tag, ".dropped"},  128'(dropped_out), 128'd0);
    endtask

    initial begin
        rst_in = 1'b1; host_word_in = '0; host_word_valid_in = 1'b0;
        query_ready_in = 1'b0; result_in = '0; result_valid_in = 1'b0;
        result_last_in = 1'b0; result_ack_in = 1'b0;
        tick(); tick();
        check_reset_state("reset");
        rst_in = 1'b0;

        // Basic frame with engine always ready
        query_ready_in = 1'b1;
        send(32'hFFFF_FFFF);
        check("t1.collect", 128'(state_out), 128'd1);
        check("t1.busy_collect", 128'(busy_out), 128'd0);
        send(32'd5); send(32'd7); send(32'd1); send(32'd1); send(32'd3);
        check("t1.still_collect", 128'(state_out), 128'd1);
        send(32'd42);
        check("t1.issue", 128'(state_out), 128'd2);
        check("t1.qvalid", 128'(query_valid_out), 128'd1);
        check("t1.query", query_out, QV);
        check("t1.k", 128'(k_out), 128'd3);
        check("t1.vid", 128'(vertex_id_out), 128'd42);
        check("t1.busy", 128'(busy_out), 128'd1);
        tick();
        check("t1.run", 128'(state_out), 128'd3);
        check("t1.qvalid_drop", 128'(query_valid_out), 128'd0);
        push(32'd77, 1'b1, 1'b0);
        check("t1.done", 128'(state_out), 128'd4);
        check("t1.rvalid", 128'(result_valid_out), 128'd1);
        check("t1.rout", 128'(result_out), 128'd77);
        tick();
        check("t1.idle", 128'(state_out), 128'd0);
        push(32'd88, 1'b0, 1'b0);
        check("idle_result_ignored", 128'(result_out), 128'd77);

        // Resync on repeated sync, then back-pressure for 10 cycles
        query_ready_in = 1'b0;
        send(32'hFFFF_FFFF); send(32'd9); send(32'd9);
        send_frame();
        check("t2.issue", 128'(state_out), 128'd2);
        check("t2.query", query_out, QV);
        check("t2.k", 128'(k_out), 128'd3);
        check("t2.vid", 128'(vertex_id_out), 128'd42);
        check("t2.queue_cleared", 128'(result_valid_out), 128'd0);
        check("t2.dropped_clear", 128'(dropped_out), 128'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) send(32'd123);
            else        tick();
            check("t3.qvalid_hold", 128'(query_valid_out), 128'd1);
        end
        check("t3.query_hold", query_out, QV);
        check("t3.k_hold", 128'(k_out), 128'd3);
        check("t3.vid_hold", 128'(vertex_id_out), 128'd42);
        check("t3.dropped", 128'(dropped_out), 128'd1);
        query_ready_in = 1'b1;
        tick();
        check("t3.run", 128'(state_out), 128'd3);

        // Engine returns 10..19, queue overflows
        for (int v = 10; v <= 19; v++) push(32'(v), v == 19, 1'b0);
        check("t4.done", 128'(state_out), 128'd4);
        check("t4.overflow", 128'(overflow_out), 128'd1);
        check("t4.cycles", 128'(cycles_out), 128'(exp_cyc(10)));
        tick();
        check("t4.idle", 128'(state_out), 128'd0);
        check("t4.cycles_hold", 128'(cycles_out), 128'(exp_cyc(10)));
        for (int v = 10; v <= 17; v++) begin
            check("t4.pop_valid", 128'(result_valid_out), 128'd1);
            check("t4.pop_data", 128'(result_out), 128'(v));
            pop();
        end
        check("t4.empty", 128'(result_valid_out), 128'd0);
        pop();
        check("t4.pop_empty_valid", 128'(result_valid_out), 128'd0);
        check("t4.pop_empty_data", 128'(result_out), 128'd0);

        // Push and pop together while full
        send(32'hFFFF_FFFF);
        check("t5.dropped_cleared", 128'(dropped_out), 128'd0);
        send(32'd5); send(32'd7); send(32'd1); send(32'd1); send(32'd3); send(32'd42);
        check("t5.issue", 128'(state_out), 128'd2);
        check("t5.overflow_cleared", 128'(overflow_out), 128'd0);
        tick();
        for (int v = 100; v <= 107; v++) push(32'(v), 1'b0, 1'b0);
        check("t5.full_head", 128'(result_out), 128'd100);
        check("t5.full_no_ovf", 128'(overflow_out), 128'd0);
        push(32'd108, 1'b0, 1'b1);
        check("t5.pushpop_head", 128'(result_out), 128'd101);
        check("t5.pushpop_no_ovf", 128'(overflow_out), 128'd0);
        push(32'd109, 1'b1, 1'b1);
        check("t5.done", 128'(state_out), 128'd4);
        check("t5.no_ovf", 128'(overflow_out), 128'd0);
        tick();
        for (int v = 102; v <= 109; v++) begin
            check("t5.pop_data", 128'(result_out), 128'(v));
            pop();
        end
        check("t5.empty", 128'(result_valid_out), 128'd0);
        check("t5.cycles", 128'(cycles_out), 128'(exp_cyc(10)));

        // Latency of 25 cycles
        send_frame();
        check("t6.cycles_cleared", 128'(cycles_out), 128'd0);
        tick();
        check("t6.run", 128'(state_out), 128'd3);
        repeat (24) tick();
        push(32'd55, 1'b1, 1'b0);
        check("t6.done", 128'(state_out), 128'd4);
        check("t6.cycles", 128'(cycles_out), 128'(exp_cyc(25)));
        tick();
        check("t6.cycles_hold", 128'(cycles_out), 128'(exp_cyc(25)));

        // Reset during RUN
        send_frame();
        tick();
        push(32'd66, 1'b0, 1'b0);
        send(32'd1);
        check("t7.pre_dropped", 128'(dropped_out), 128'd1);
        check("t7.pre_rvalid", 128'(result_valid_out), 128'd1);
        rst_in = 1'b1;
        tick();
        check_reset_state("t7");
        rst_in = 1'b0;

        // Reset mid-frame abandons the frame
        send(32'hFFFF_FFFF); send(32'd5);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        send(32'd7); send(32'd1); send(32'd1); send(32'd3); send(32'd42);
        check("t8.state", 128'(state_out), 128'd0);
        check("t8.qvalid", 128'(query_valid_out), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
